// File: rtl/t_flipflop_bank.sv
// t_flipflop_bank
// WIDTH-bit bank of T flip-flops with four modes: per-bit toggle, parallel
// load, and synchronous up/down counting built from a T-chain. The counter
// toggle enables come from prefix AND (up) and prefix NOR (down) of q, so no
// adder is inferred. tc flags the counting limit for the current mode, and
// limit_evt is a registered one-cycle pulse after a count edge taken at the
// limit. That edge either wraps or saturates, depending on SATURATE.

module t_flipflop_bank #(
    parameter int          WIDTH       = 4,
    parameter bit          SATURATE    = 1'b0,
    parameter logic [31:0] RESET_VALUE = 32'd0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             sclr,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] t,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             limit_evt
);

    localparam logic [WIDTH-1:0] RST_Q = RESET_VALUE[WIDTH-1:0];

    localparam logic [1:0] MODE_TOGGLE = 2'b00;
    localparam logic [1:0] MODE_LOAD   = 2'b01;
    localparam logic [1:0] MODE_UP     = 2'b10;
    localparam logic [1:0] MODE_DOWN   = 2'b11;

    logic [WIDTH-1:0] up_tog;
    logic [WIDTH-1:0] dn_tog;
    logic             ones_acc;
    logic             zeros_acc;
    logic [WIDTH-1:0] q_next;
    logic             evt_next;

    // Prefix AND / NOR chain: bit i toggles when every lower bit is 1 (up) or 0 (down)
    always_comb begin
        up_tog    = '0;
        dn_tog    = '0;
        ones_acc  = 1'b1;
        zeros_acc = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            up_tog[i] = ones_acc;
            dn_tog[i] = zeros_acc;
            ones_acc  = ones_acc & q[i];
            zeros_acc = zeros_acc & ~q[i];
        end
    end

    // Terminal count follows q and the current mode with no register in between
    always_comb begin
        tc = 1'b0;
        case (mode)
            MODE_UP:   tc = &q;
            MODE_DOWN: tc = ~|q;
            default:   tc = 1'b0;
        endcase
    end

    // Next state for an enabled edge; a count at the limit holds when saturating
    always_comb begin
        q_next   = q;
        evt_next = 1'b0;
        case (mode)
            MODE_TOGGLE: q_next = q ^ t;
            MODE_LOAD:   q_next = d;
            MODE_UP: begin
                evt_next = tc;
                if (!(SATURATE && tc)) begin
                    q_next = q ^ up_tog;
                end
            end
            MODE_DOWN: begin
                evt_next = tc;
                if (!(SATURATE && tc)) begin
                    q_next = q ^ dn_tog;
                end
            end
            default: q_next = q;
        endcase
    end

    // State register: async clear, then sync clear, then enable gating
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            q         <= RST_Q;
            limit_evt <= 1'b0;
        end else if (sclr) begin
            q         <= RST_Q;
            limit_evt <= 1'b0;
        end else if (en) begin
            q         <= q_next;
            limit_evt <= evt_next;
        end
    end

endmodule

// File: tb/tb_t_flipflop_bank.sv
// tb_t_flipflop_bank
// Directed checks on two 4-bit banks (wrapping with zero reset value, and
// saturating with reset value 0101), followed by a random run on two 8-bit
// banks compared against a behavioural model.

module tb_t_flipflop_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // 4-bit group stimulus
    logic       clr4 = 1'b1;
    logic       sclr4 = 1'b0;
    logic       en4 = 1'b0;
    logic [1:0] mode4 = 2'b00;
    logic [3:0] t4 = '0;
    logic [3:0] d4 = '0;
    logic [3:0] qa, qb;
    logic       tca, tcb, eva, evb;

    // 8-bit group stimulus
    logic       clr8 = 1'b1;
    logic       sclr8 = 1'b0;
    logic       en8 = 1'b0;
    logic [1:0] mode8 = 2'b00;
    logic [7:0] t8 = '0;
    logic [7:0] d8 = '0;
    logic [7:0] qc, qd;
    logic       tcc, tcd, evc, evd;

    localparam logic [7:0] RV_D = 8'hA5;

    t_flipflop_bank #(.WIDTH(4), .SATURATE(1'b0), .RESET_VALUE(32'h0)) dutA (
        .clk(clk), .clr(clr4), .sclr(sclr4), .en(en4), .mode(mode4),
        .t(t4), .d(d4), .q(qa), .tc(tca), .limit_evt(eva));

    t_flipflop_bank #(.WIDTH(4), .SATURATE(1'b1), .RESET_VALUE(32'h5)) dutB (
        .clk(clk), .clr(clr4), .sclr(sclr4), .en(en4), .mode(mode4),
        .t(t4), .d(d4), .q(qb), .tc(tcb), .limit_evt(evb));

    t_flipflop_bank #(.WIDTH(8), .SATURATE(1'b0), .RESET_VALUE(32'h0)) dutC (
        .clk(clk), .clr(clr8), .sclr(sclr8), .en(en8), .mode(mode8),
        .t(t8), .d(d8), .q(qc), .tc(tcc), .limit_evt(evc));

    t_flipflop_bank #(.WIDTH(8), .SATURATE(1'b1), .RESET_VALUE({24'h0, RV_D})) dutD (
        .clk(clk), .clr(clr8), .sclr(sclr8), .en(en8), .mode(mode8),
        .t(t8), .d(d8), .q(qd), .tc(tcd), .limit_evt(evd));

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Drive the 4-bit group controls
    task automatic applyStimulus(input logic s, input logic e, input logic [1:0] m,
                                 input logic [3:0] tv, input logic [3:0] dv);
        sclr4 = s;
        en4   = e;
        mode4 = m;
        t4    = tv;
        d4    = dv;
    endtask

    // Advance to just after the next rising edge
    task automatic waitEdge();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] modelNext(input logic [7:0] q, input logic [1:0] m,
                                             input logic [7:0] tv, input logic [7:0] dv,
                                             input bit sat);
        case (m)
            2'b00:   return q ^ tv;
            2'b01:   return dv;
            2'b10:   return (sat && q == 8'hFF) ? q : q + 8'd1;
            default: return (sat && q == 8'h00) ? q : q - 8'd1;
        endcase
    endfunction

    function automatic logic modelLimit(input logic [7:0] q, input logic [1:0] m);
        if (m == 2'b10) return q == 8'hFF;
        if (m == 2'b11) return q == 8'h00;
        return 1'b0;
    endfunction

    // Watchdog so the run always terminates
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [7:0] mc, md;
        logic       ec, ed;
        logic       rs, re;
        logic [1:0] rm;
        logic [7:0] rt, rd;

        // Reset values while clr is held
        repeat (2) waitEdge();
        clr4 = 1'b0;
        #1;
        checkOutput("rstA_q", 32'(qa), 32'h0);
        checkOutput("rstA_evt", 32'(eva), 32'h0);
        checkOutput("rstB_q", 32'(qb), 32'h5);

        // Load, then an async clear pulse in mid-cycle
        applyStimulus(1'b0, 1'b1, 2'b01, 4'h0, 4'b1001);
        waitEdge();
        checkOutput("loadA", 32'(qa), 32'h9);
        #2 clr4 = 1'b1;
        #3;
        checkOutput("asyncA_q", 32'(qa), 32'h0);
        checkOutput("asyncA_evt", 32'(eva), 32'h0);
        checkOutput("asyncB_q", 32'(qb), 32'h5);
        applyStimulus(1'b0, 1'b1, 2'b00, 4'b0011, 4'h0);
        #7 clr4 = 1'b0;
        waitEdge();
        checkOutput("postclrA", 32'(qa), 32'h3);
        checkOutput("postclrB", 32'(qb), 32'h6);

        // Toggle mode
        applyStimulus(1'b0, 1'b1, 2'b01, 4'h0, 4'h0);
        waitEdge();
        applyStimulus(1'b0, 1'b1, 2'b00, 4'b0001, 4'h0);
        for (int i = 0; i < 4; i++) begin
            waitEdge();
            checkOutput("togbit0", 32'(qa), (i % 2 == 0) ? 32'h1 : 32'h0);
            checkOutput("togtc", 32'(tca), 32'h0);
        end
        applyStimulus(1'b0, 1'b1, 2'b00, 4'b1010, 4'h0);
        waitEdge();
        checkOutput("tog1010", 32'(qa), 32'hA);
        applyStimulus(1'b0, 1'b1, 2'b00, 4'b0000, 4'h0);
        repeat (2) begin
            waitEdge();
            checkOutput("toghold", 32'(qa), 32'hA);
        end

        // Up count from 0110 with wrap
        applyStimulus(1'b0, 1'b1, 2'b01, 4'h0, 4'b0110);
        waitEdge();
        checkOutput("load0110", 32'(qa), 32'h6);
        applyStimulus(1'b0, 1'b1, 2'b10, 4'h0, 4'h0);
        #1;
        checkOutput("uptc0", 32'(tca), 32'h0);
        for (int i = 1; i <= 9; i++) begin
            waitEdge();
            checkOutput("upq", 32'(qa), 32'(6 + i));
            checkOutput("uptc", 32'(tca), (6 + i == 15) ? 32'h1 : 32'h0);
            checkOutput("upevt", 32'(eva), 32'h0);
        end
        waitEdge();
        checkOutput("wrapq", 32'(qa), 32'h0);
        checkOutput("wrapevt", 32'(eva), 32'h1);
        checkOutput("wraptc", 32'(tca), 32'h0);
        waitEdge();
        checkOutput("afterwrapq", 32'(qa), 32'h1);
        checkOutput("afterwrapevt", 32'(eva), 32'h0);

        // Down count from 0010 with saturation
        applyStimulus(1'b0, 1'b1, 2'b01, 4'h0, 4'b0010);
        waitEdge();
        checkOutput("load0010", 32'(qb), 32'h2);
        applyStimulus(1'b0, 1'b1, 2'b11, 4'h0, 4'h0);
        waitEdge();
        checkOutput("dn1q", 32'(qb), 32'h1);
        checkOutput("dn1tc", 32'(tcb), 32'h0);
        waitEdge();
        checkOutput("dn0q", 32'(qb), 32'h0);
        checkOutput("dn0tc", 32'(tcb), 32'h1);
        checkOutput("dn0evt", 32'(evb), 32'h0);
        repeat (2) begin
            waitEdge();
            checkOutput("satq", 32'(qb), 32'h0);
            checkOutput("satevt", 32'(evb), 32'h1);
        end
        applyStimulus(1'b0, 1'b1, 2'b10, 4'h0, 4'h0);
        #1;
        checkOutput("modeswtc", 32'(tcb), 32'h0);

        // Sync clear beats load; then en=0 holds state and pulse
        applyStimulus(1'b1, 1'b1, 2'b01, 4'h0, 4'b1111);
        waitEdge();
        checkOutput("sclrB_q", 32'(qb), 32'h5);
        checkOutput("sclrB_evt", 32'(evb), 32'h0);
        checkOutput("sclrA_q", 32'(qa), 32'h0);
        applyStimulus(1'b0, 1'b0, 2'b10, 4'h0, 4'h0);
        repeat (3) begin
            waitEdge();
            checkOutput("enholdB", 32'(qb), 32'h5);
        end

        // Random run against the behavioural model on the 8-bit banks
        clr8 = 1'b0;
        mc = 8'h00; md = RV_D; ec = 1'b0; ed = 1'b0;
        #1;
        checkOutput("rstC_q", 32'(qc), 32'(mc));
        checkOutput("rstD_q", 32'(qd), 32'(md));
        for (int n = 0; n < 1000; n++) begin
            rs = ($urandom_range(15) == 0);
            re = ($urandom_range(3) != 0);
            rm = 2'($urandom_range(3));
            rt = 8'($urandom);
            case ($urandom_range(4))
                0:       rd = 8'h00;
                1:       rd = 8'hFF;
                2:       rd = 8'hFE;
                3:       rd = 8'h01;
                default: rd = 8'($urandom);
            endcase
            sclr8 = rs; en8 = re; mode8 = rm; t8 = rt; d8 = rd;
            #1;
            checkOutput("rndC_tc", 32'(tcc), 32'(modelLimit(mc, rm)));
            checkOutput("rndD_tc", 32'(tcd), 32'(modelLimit(md, rm)));
            waitEdge();
            if (rs) begin
                mc = 8'h00; md = RV_D; ec = 1'b0; ed = 1'b0;
            end else if (re) begin
                ec = modelLimit(mc, rm);
                ed = modelLimit(md, rm);
                mc = modelNext(mc, rm, rt, rd, 1'b0);
                md = modelNext(md, rm, rt, rd, 1'b1);
            end
            checkOutput("rndC_q", 32'(qc), 32'(mc));
            checkOutput("rndC_evt", 32'(evc), 32'(ec));
            checkOutput("rndD_q", 32'(qd), 32'(md));
            checkOutput("rndD_evt", 32'(evd), 32'(ed));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/t_flipflop_bank.md
Name: t_flipflop_bank

Overview:
- Parametrised successor to the single-bit T flip-flop with clear.
- WIDTH-bit bank of T flip-flops. Four modes:
  - per-bit toggle
  - parallel load
  - synchronous up count, built from a T-chain
  - synchronous down count, built from a T-chain
- Used as a general toggle register or small counter in training and datapath blocks.
- Provides terminal-count and registered limit-event flags.

Parameters:
- WIDTH, 4, number of flip-flops in the bank (1 to 32).
- SATURATE, 0. 0 = counter wraps at the limit. 1 = counter holds at the limit.
- RESET_VALUE, 0, value loaded into q by the async and sync clears (WIDTH bits, truncated).

Ports:
- clk, input, 1, rising-edge clock.
- clr, input, 1, asynchronous active-high clear.
- sclr, input, 1, synchronous clear to RESET_VALUE.
- en, input, 1, clock enable. 0 = hold.
- mode, input, 2. 00 toggle, 01 load, 10 count up, 11 count down.
- t, input, WIDTH, per-bit toggle enables (mode 00 only).
- d, input, WIDTH, parallel load data (mode 01 only).
- q, output, WIDTH, bank state.
- tc, output, 1, terminal count, combinational.
- limit_evt, output, 1, registered one-cycle pulse.

Behaviour:
- Clock and reset are fixed: one clock, clk. Reset clr is asynchronous and active-high.
- clr=1 takes effect immediately, independent of clk:
  - q = RESET_VALUE
  - limit_evt = 0
  - Both hold while clr=1.
- Release of clr: the first active edge after clr falls behaves normally. No extra latency.
- Priority at each rising edge: clr, then sclr, then en=0, then mode.
- sclr=1: q <= RESET_VALUE, limit_evt <= 0. This overrides en and mode.
- en=0: q and limit_evt hold their values. limit_evt is therefore cleared only by clr or sclr, or by the next enabled edge.
- Mode 00 (toggle): q[i] <= q[i] ^ t[i] for every bit. t=0 holds. All-ones inverts q.
- Mode 01 (load): q <= d.
- Mode 10 (up): T-chain.
  - Bit i toggles when all of q[i-1:0] = 1. Bit 0 always toggles.
  - Result equals q+1 mod 2^WIDTH.
- Mode 11 (down): T-chain.
  - Bit i toggles when all of q[i-1:0] = 0. Bit 0 always toggles.
  - Result equals q-1 mod 2^WIDTH.
- Per-bit toggle enables must be built from prefix AND/NOR of q. No adder is inferred.
- Latency: every update is visible on q one cycle after the sampling edge.
- tc (combinational from q and mode):
  - mode 10: tc = (q == all ones)
  - mode 11: tc = (q == 0)
  - modes 00 and 01: tc = 0
- Limit handling on an enabled count edge with tc=1:
  - SATURATE=0: q wraps (all ones -> 0 up; 0 -> all ones down).
  - SATURATE=1: q is unchanged.
- limit_evt is a registered pulse:
  - It is 1 in the cycle after any enabled count edge taken with tc=1 (wrap or saturate).
  - Any other enabled edge sets it to 0.
- Mode change: may occur on any cycle. The new mode is used at the next edge and tc follows it immediately.
- WIDTH=1:
  - Up and down both toggle bit 0.
  - tc = q (up) or ~q (down).

Test Plan:
- WIDTH=4, pulse clr for 10 ns mid-cycle -> q=0000 and limit_evt=0 immediately, without waiting for a clock edge. First edge after release acts normally.
- Toggle mode:
  - q=0000, t=0001 over 4 edges -> q bit0 sequence 1,0,1,0.
  - Then t=1010 -> q=1010.
  - Then t=0000 -> q holds.
- Load d=0110, then up count for 10 edges, SATURATE=0 -> q=0111, then 1000, and onward up to 1111. tc=1 at q=1111. Next edge gives q=0000 and limit_evt=1 for exactly one cycle.
- Down count from 0010, SATURATE=1 -> q=0001, then 0000. tc=1 at 0000. Next two edges: q stays 0000 and limit_evt stays 1. Switching to mode 10 -> tc=0 immediately.
- Simultaneous sclr=1, en=1, mode=01, d=1111 with RESET_VALUE=0101 -> q=0101. With en=0 and mode 10 -> q holds across 3 edges.
- Random test, 1000 cycles, WIDTH=8 -> q matches a behavioural model (q^t, d, q+1, q-1 with wrap/saturate). tc and limit_evt match every cycle.
